// File: rtl/ntsc_timing_sequencer.sv
// Master line/field sequencer for the NTSC composite generator, clocked at 16*fsc.
// Define NTSC_INTERLACE_EN for 480i (525 half-lines per field, alternating field start); default is 240p.
module ntsc_timing_sequencer (
    input  logic       phaseClock,
    input  logic       reset,
    output logic [3:0] subcarrierPhase,
    output logic       sync,
    output logic       blank,
    output logic       burst,
    output logic       pixelReq,
    output logic [8:0] pixelX,
    output logic [7:0] pixelY,
    output logic       field,
    output logic       frameStart
);

    localparam logic [11:0] H_TOTAL      = 12'd3640;
    localparam logic [11:0] H_HALF       = 12'd1820;
    localparam logic [11:0] H_SYNC       = 12'd269;
    localparam logic [11:0] EQ_WIDTH     = 12'd134;
    localparam logic [11:0] BROAD_WIDTH  = 12'd1551;
    localparam logic [11:0] BURST_START  = 12'd306;
    localparam logic [11:0] BURST_END    = 12'd450;
    localparam logic [11:0] ACT_START    = 12'd624;
    localparam logic [11:0] ACT_END      = 12'd3184;
    localparam logic [11:0] PIXEL_LEAD   = 12'd4;
    localparam logic [9:0]  ACT_HL_FIRST = 10'd42;
    localparam logic [9:0]  ACT_HL_END   = 10'd522;
    localparam logic [8:0]  ACT_LINE_0   = 9'd21;

`ifdef NTSC_INTERLACE_EN
    localparam logic [9:0]  HL_TOTAL     = 10'd525;
`else
    localparam logic [9:0]  HL_TOTAL     = 10'd524;
`endif

    typedef enum logic [1:0] {
        HL_EQUALIZE = 2'd0,
        HL_BROAD    = 2'd1,
        HL_NORMAL   = 2'd2
    } hl_class_t;

    logic [11:0] h_r;
    logic [9:0]  hl_r;
    logic [3:0]  phase_r;
    logic        field_r;

    logic        h_wrap_s;
    logic        hl_step_s;
    logic        hl_wrap_s;
    logic [11:0] h_next_s;
    logic [9:0]  hl_next_s;

    hl_class_t   hl_class_s;
    logic [11:0] hh_s;
    logic        sync_s;
    logic        act_line_s;
    logic        active_s;
    logic        blank_s;
    logic        burst_s;
    logic [11:0] h_lead_s;
    logic [11:0] pix_off_s;
    logic        pix_req_s;
    logic [7:0]  pix_row_s;
    logic        frame_start_s;

    // Counter next-state: hl advances on entry to h=0 and h=1820, together with the h wrap.
    always_comb begin
        h_wrap_s  = (h_r == (H_TOTAL - 12'd1));
        hl_step_s = h_wrap_s || (h_r == (H_HALF - 12'd1));
        hl_wrap_s = hl_step_s && (hl_r == (HL_TOTAL - 10'd1));
        if (h_wrap_s) begin
            h_next_s = 12'd0;
        end else begin
            h_next_s = h_r + 12'd1;
        end
        if (hl_wrap_s) begin
            hl_next_s = 10'd0;
        end else if (hl_step_s) begin
            hl_next_s = hl_r + 10'd1;
        end else begin
            hl_next_s = hl_r;
        end
    end

    // Half-line classification for the vertical interval.
    always_comb begin
        if (hl_r < 10'd6) begin
            hl_class_s = HL_EQUALIZE;
        end else if (hl_r < 10'd12) begin
            hl_class_s = HL_BROAD;
        end else if (hl_r < 10'd18) begin
            hl_class_s = HL_EQUALIZE;
        end else begin
            hl_class_s = HL_NORMAL;
        end
    end

    // Combinational output decode from the current counter state.
    always_comb begin
        if (h_r >= H_HALF) begin
            hh_s = h_r - H_HALF;
        end else begin
            hh_s = h_r;
        end

        // Normal-line sync is keyed to h=0 only; the mid-line half never carries hsync.
        case (hl_class_s)
            HL_EQUALIZE: sync_s = (hh_s < EQ_WIDTH);
            HL_BROAD:    sync_s = (hh_s < BROAD_WIDTH);
            HL_NORMAL:   sync_s = (h_r < H_SYNC);
            default:     sync_s = 1'b0;
        endcase

        act_line_s = (hl_r >= ACT_HL_FIRST) && (hl_r < ACT_HL_END);
        active_s   = act_line_s && (h_r >= ACT_START) && (h_r < ACT_END);
        blank_s    = !active_s || sync_s;
        burst_s    = (hl_class_s == HL_NORMAL) && (h_r >= BURST_START) &&
                     (h_r < BURST_END) && !sync_s;

        // Fetch runs PIXEL_LEAD clocks ahead so pixel data lands with the active clock.
        h_lead_s  = h_r + PIXEL_LEAD;
        pix_off_s = h_lead_s - ACT_START;
        pix_req_s = act_line_s && (h_lead_s >= ACT_START) && (h_lead_s < ACT_END) &&
                    (pix_off_s[2:0] == 3'd0);
        pix_row_s = 8'(hl_r[9:1] - ACT_LINE_0);

        frame_start_s = (hl_r == 10'd0) && (hh_s == 12'd0);
    end

    // Horizontal, half-line and subcarrier phase counters.
    always_ff @(posedge phaseClock) begin
        if (reset) begin
            h_r     <= 12'd0;
            hl_r    <= 10'd0;
            phase_r <= 4'd0;
        end else begin
            h_r     <= h_next_s;
            hl_r    <= hl_next_s;
            phase_r <= phase_r + 4'd1;
        end
    end

`ifdef NTSC_INTERLACE_EN
    // Field parity flips on every half-line wrap.
    always_ff @(posedge phaseClock) begin
        if (reset) begin
            field_r <= 1'b0;
        end else if (hl_wrap_s) begin
            field_r <= ~field_r;
        end else begin
            field_r <= field_r;
        end
    end
`else
    // Progressive frames carry a single field.
    always_ff @(posedge phaseClock) begin
        field_r <= 1'b0;
    end
`endif

    // Output register stage: every output reflects the counter state one clock earlier.
    always_ff @(posedge phaseClock) begin
        if (reset) begin
            subcarrierPhase <= 4'd0;
            sync            <= 1'b0;
            blank           <= 1'b1;
            burst           <= 1'b0;
            pixelReq        <= 1'b0;
            pixelX          <= 9'd0;
            pixelY          <= 8'd0;
            field           <= 1'b0;
            frameStart      <= 1'b0;
        end else begin
            subcarrierPhase <= phase_r;
            sync            <= sync_s;
            blank           <= blank_s;
            burst           <= burst_s;
            pixelReq        <= pix_req_s;
            field           <= field_r;
            frameStart      <= frame_start_s;
            if (pix_req_s) begin
                pixelX <= pix_off_s[11:3];
                pixelY <= pix_row_s;
            end else begin
                pixelX <= pixelX;
                pixelY <= pixelY;
            end
        end
    end

endmodule

// File: tb/tb_ntsc_timing_sequencer.sv
// Directed bench for ntsc_timing_sequencer: reset, vertical interval, a normal line and the first active lines.
module tb_ntsc_timing_sequencer;

    logic       phaseClock = 1'b0;
    logic       reset      = 1'b1;
    logic [3:0] subcarrierPhase;
    logic       sync;
    logic       blank;
    logic       burst;
    logic       pixelReq;
    logic [8:0] pixelX;
    logic [7:0] pixelY;
    logic       field;
    logic       frameStart;

    int checks      = 0;
    int passes      = 0;
    int n           = -1;
    int early_burst = 0;
    int early_req   = 0;
    int field_errs  = 0;

    always #5 phaseClock = ~phaseClock;

    ntsc_timing_sequencer dut (
        .phaseClock      (phaseClock),
        .reset           (reset),
        .subcarrierPhase (subcarrierPhase),
        .sync            (sync),
        .blank           (blank),
        .burst           (burst),
        .pixelReq        (pixelReq),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .field           (field),
        .frameStart      (frameStart)
    );

    // n is the counter position (clocks since reset release) the outputs now reflect.
    task automatic step();
        @(posedge phaseClock);
        #1;
        n = n + 1;
        if ((n / 1820) < 18 && burst !== 1'b0) early_burst++;
        if (n < 76440 && pixelReq !== 1'b0) early_req++;
        if (field !== 1'b0) field_errs++;
    endtask

    task automatic advance_to(input int target);
        while (n < target) step();
    endtask

    task automatic test_reset();
        logic [26:0] want;
        want = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 9'd0, 8'd0};
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge phaseClock);
            #1;
            checks++;
            if (blank !== 1'b1) $display("FAIL reset_blank cycle %0d: got %b want 1", i, blank);
            else passes++;
            checks++;
            if (sync !== 1'b0) $display("FAIL reset_sync cycle %0d: got %b want 0", i, sync);
            else passes++;
        end
        checks++;
        if ({sync, blank, burst, pixelReq, frameStart, field, subcarrierPhase, pixelX, pixelY} !== want)
            $display("FAIL reset_outputs: got %h want %h",
                     {sync, blank, burst, pixelReq, frameStart, field, subcarrierPhase, pixelX, pixelY}, want);
        else passes++;
        reset = 1'b0;
        n = -1;
    endtask

    task automatic test_first_line();
        int sync_cnt, fs_cnt, second_rise, phase_errs;
        logic prev_sync;
        step();
        checks++;
        if (sync !== 1'b1) $display("FAIL first_sync: got %b want 1", sync); else passes++;
        checks++;
        if (frameStart !== 1'b1) $display("FAIL first_frame_start: got %b want 1", frameStart); else passes++;
        checks++;
        if (subcarrierPhase !== 4'd0) $display("FAIL first_phase: got %0d want 0", subcarrierPhase); else passes++;
        sync_cnt = 1; fs_cnt = 0; second_rise = -1; phase_errs = 0; prev_sync = sync;
        while (n < 3639) begin
            step();
            if (sync === 1'b1) sync_cnt++;
            if (frameStart !== 1'b0) fs_cnt++;
            if (sync === 1'b1 && prev_sync === 1'b0 && second_rise < 0) second_rise = n;
            if (subcarrierPhase !== 4'(n)) phase_errs++;
            prev_sync = sync;
        end
        checks++;
        if (sync_cnt != 268) $display("FAIL eq_sync_count: got %0d want 268", sync_cnt); else passes++;
        checks++;
        if (second_rise != 1820) $display("FAIL eq_second_pulse: got %0d want 1820", second_rise); else passes++;
        checks++;
        if (fs_cnt != 0) $display("FAIL extra_frame_start: got %0d want 0", fs_cnt); else passes++;
        checks++;
        if (phase_errs != 0) $display("FAIL phase_track: got %0d errors want 0", phase_errs); else passes++;
        step();
        checks++;
        if (subcarrierPhase !== 4'd8) $display("FAIL line1_phase: got %0d want 8", subcarrierPhase); else passes++;
        checks++;
        if (sync !== 1'b1) $display("FAIL line1_start_sync: got %b want 1", sync); else passes++;
    endtask

    task automatic test_broad();
        int cnt, edge_errs, eq_cnt;
        edge_errs = 0;
        advance_to(10919);
        for (int hlx = 6; hlx < 12; hlx++) begin
            cnt = 0;
            for (int i = 0; i < 1820; i++) begin
                step();
                if (sync === 1'b1) cnt++;
                if (i == 0 && sync !== 1'b1) edge_errs++;
                if (i == 1550 && sync !== 1'b1) edge_errs++;
                if (i == 1551 && sync !== 1'b0) edge_errs++;
            end
            checks++;
            if (cnt != 1551) $display("FAIL broad_width hl %0d: got %0d want 1551", hlx, cnt); else passes++;
        end
        checks++;
        if (edge_errs != 0) $display("FAIL broad_edges: got %0d errors want 0", edge_errs); else passes++;
        eq_cnt = 0;
        for (int i = 0; i < 6 * 1820; i++) begin
            step();
            if (sync === 1'b1) eq_cnt++;
        end
        checks++;
        if (eq_cnt != 804) $display("FAIL post_eq_sync_count: got %0d want 804", eq_cnt); else passes++;
    endtask

    task automatic test_normal_line();
        int s_cnt, s_first, s_last, b_cnt, b_first, b_last, r_cnt, bl_low;
        s_cnt = 0; s_first = -1; s_last = -1; b_cnt = 0; b_first = -1; b_last = -1; r_cnt = 0; bl_low = 0;
        advance_to(32759);
        for (int h = 0; h < 3640; h++) begin
            step();
            if (sync === 1'b1) begin
                s_cnt++;
                if (s_first < 0) s_first = h;
                s_last = h;
            end
            if (burst === 1'b1) begin
                b_cnt++;
                if (b_first < 0) b_first = h;
                b_last = h;
            end
            if (pixelReq !== 1'b0) r_cnt++;
            if (blank !== 1'b1) bl_low++;
        end
        checks++;
        if (s_cnt != 269) $display("FAIL hsync_width: got %0d want 269", s_cnt); else passes++;
        checks++;
        if (s_first != 0 || s_last != 268) $display("FAIL hsync_span: got %0d..%0d want 0..268", s_first, s_last); else passes++;
        checks++;
        if (b_cnt != 144) $display("FAIL burst_width: got %0d want 144", b_cnt); else passes++;
        checks++;
        if (b_first != 306 || b_last != 449) $display("FAIL burst_span: got %0d..%0d want 306..449", b_first, b_last); else passes++;
        checks++;
        if (r_cnt != 0) $display("FAIL normal_line_req: got %0d want 0", r_cnt); else passes++;
        checks++;
        if (bl_low != 0) $display("FAIL normal_line_blank: got %0d unblanked want 0", bl_low); else passes++;
        checks++;
        if (early_burst != 0) $display("FAIL vblank_burst: got %0d want 0", early_burst); else passes++;
    endtask

    task automatic test_active_line();
        int r_cnt, first_h, px_errs, py_errs, bl_low, bl_first, bl_last;
        logic [8:0] first_x, last_x;
        logic [7:0] first_y;
        r_cnt = 0; first_h = -1; px_errs = 0; py_errs = 0; bl_low = 0; bl_first = -1; bl_last = -1;
        first_x = 9'h1ff; last_x = 9'h1ff; first_y = 8'hff;
        advance_to(76439);
        checks++;
        if (early_req != 0) $display("FAIL req_before_line21: got %0d want 0", early_req); else passes++;
        for (int h = 0; h < 3640; h++) begin
            step();
            if (pixelReq === 1'b1) begin
                if (r_cnt == 0) begin
                    first_h = h; first_x = pixelX; first_y = pixelY;
                end
                if (pixelX !== 9'(r_cnt)) px_errs++;
                if (pixelY !== 8'd0) py_errs++;
                last_x = pixelX;
                r_cnt++;
            end
            if (blank === 1'b0) begin
                bl_low++;
                if (bl_first < 0) bl_first = h;
                bl_last = h;
            end
        end
        checks++;
        if (r_cnt != 320) $display("FAIL req_count: got %0d want 320", r_cnt); else passes++;
        checks++;
        if (first_h != 620) $display("FAIL first_req_h: got %0d want 620", first_h); else passes++;
        checks++;
        if (first_x !== 9'd0 || first_y !== 8'd0) $display("FAIL first_req_xy: got %0d,%0d want 0,0", first_x, first_y); else passes++;
        checks++;
        if (last_x !== 9'd319) $display("FAIL last_req_x: got %0d want 319", last_x); else passes++;
        checks++;
        if (px_errs != 0) $display("FAIL req_x_sequence: got %0d errors want 0", px_errs); else passes++;
        checks++;
        if (py_errs != 0) $display("FAIL req_y_line21: got %0d errors want 0", py_errs); else passes++;
        checks++;
        if (bl_low != 2560) $display("FAIL active_width: got %0d want 2560", bl_low); else passes++;
        checks++;
        if (bl_first != 624 || bl_last != 3183) $display("FAIL active_span: got %0d..%0d want 624..3183", bl_first, bl_last); else passes++;
        advance_to(80699);
        checks++;
        if (pixelX !== 9'd319 || pixelY !== 8'd0 || pixelReq !== 1'b0)
            $display("FAIL pixel_hold: got x=%0d y=%0d req=%b want x=319 y=0 req=0", pixelX, pixelY, pixelReq);
        else passes++;
        step();
        checks++;
        if (pixelReq !== 1'b1 || pixelX !== 9'd0 || pixelY !== 8'd1)
            $display("FAIL line22_first_req: got req=%b x=%0d y=%0d want req=1 x=0 y=1", pixelReq, pixelX, pixelY);
        else passes++;
    endtask

    task automatic test_reset_abort();
        logic [26:0] want;
        want = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 9'd0, 8'd0};
        repeat (77) step();
        reset = 1'b1;
        repeat (3) begin
            @(posedge phaseClock);
            #1;
        end
        checks++;
        if ({sync, blank, burst, pixelReq, frameStart, field, subcarrierPhase, pixelX, pixelY} !== want)
            $display("FAIL abort_outputs: got %h want %h",
                     {sync, blank, burst, pixelReq, frameStart, field, subcarrierPhase, pixelX, pixelY}, want);
        else passes++;
        reset = 1'b0;
        n = -1;
        step();
        checks++;
        if (sync !== 1'b1 || frameStart !== 1'b1 || subcarrierPhase !== 4'd0 || blank !== 1'b1)
            $display("FAIL abort_restart: got sync=%b fs=%b ph=%0d blank=%b want 1 1 0 1",
                     sync, frameStart, subcarrierPhase, blank);
        else passes++;
        step();
        checks++;
        if (subcarrierPhase !== 4'd1 || frameStart !== 1'b0)
            $display("FAIL abort_second: got ph=%0d fs=%b want 1 0", subcarrierPhase, frameStart);
        else passes++;
        checks++;
        if (field_errs != 0) $display("FAIL field_held: got %0d nonzero samples want 0", field_errs); else passes++;
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_broad();
        test_normal_line();
        test_active_line();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
